// File: rtl/serial_unescape.sv
// serial_unescape: strips 0x7e flag framing and 0x7d escapes from a UART byte stream
// Ports:
//   mclk, reset          clock and asynchronous active-low reset
//   u_data, u_data_strobe raw byte from the UART receiver, one-cycle strobe per byte
//   h_data, h_data_strobe un-escaped payload byte (held) and its one-cycle strobe
//   h_frame_end           one-cycle pulse when a frame closes
//   h_frame_error         frame bad (abort, bad escape, overflow, FCS), valid with h_frame_end
//   h_length              payload byte count of the closed frame, held until the next close
// Optional: define SERIAL_UNESCAPE_FCS_EN to check a trailing CRC-16/X.25 FCS on each frame.
module serial_unescape #(
  parameter logic [7:0] FLAG    = 8'h7e,
  parameter logic [7:0] ESCAPE  = 8'h7d,
  parameter logic [7:0] ESC_XOR = 8'h20,
  parameter int         MAX_LEN = 1024,
  parameter int         LEN_W   = 11
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [7:0]       u_data,
  input  logic             u_data_strobe,
  output logic [7:0]       h_data,
  output logic             h_data_strobe,
  output logic             h_frame_end,
  output logic             h_frame_error,
  output logic [LEN_W-1:0] h_length
);
  typedef enum logic [1:0] {HUNT, DATA, ESC} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] count, count_nx;
  logic err, err_nx;
  logic emit, take, full, close, abort, set_err, clear, close_err, fcs_bad;
  logic [7:0] emit_byte;
`ifdef SERIAL_UNESCAPE_FCS_EN
  logic [15:0] crc, crc_nx;
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction
  assign fcs_bad = (crc != 16'hf0b8) || (count < LEN_W'(3));
  assign crc_nx  = clear ? 16'hffff : take ? crc_upd(crc, emit_byte) : crc;
  always_ff @(posedge mclk or negedge reset)
    if (!reset) crc <= 16'hffff;
    else crc <= crc_nx;
`else
  assign fcs_bad = 1'b0;
`endif
  always_comb begin
    state_nx  = state;
    emit      = 1'b0;
    emit_byte = u_data;
    close     = 1'b0;
    abort     = 1'b0;
    set_err   = 1'b0;
    clear     = 1'b0;
    if (u_data_strobe) begin
      case (state)
        HUNT: if (u_data == FLAG) begin
          state_nx = DATA;
          clear    = 1'b1;
        end
        DATA: begin
          // an empty frame only closes when something already went wrong in it
          if (u_data == FLAG) close = (count != '0) || err;
          else if (u_data == ESCAPE) state_nx = ESC;
          else emit = 1'b1;
        end
        default: begin
          state_nx = DATA;
          if (u_data == FLAG) begin
            close = 1'b1;
            abort = 1'b1;
          end else if (u_data == ESCAPE) set_err = 1'b1;
          else begin
            emit      = 1'b1;
            emit_byte = u_data ^ ESC_XOR;
          end
        end
      endcase
      clear = clear | close;
    end
  end
  assign full      = count == LEN_W'(MAX_LEN);
  assign take      = emit && !full;
  assign close_err = err || abort || fcs_bad;
  assign count_nx  = clear ? '0 : take ? count + 1'b1 : count;
  assign err_nx    = clear ? 1'b0 : err | set_err | (emit & full);
  always_ff @(posedge mclk or negedge reset)
    if (!reset) begin
      state         <= HUNT;
      count         <= '0;
      err           <= 1'b0;
      h_data        <= '0;
      h_data_strobe <= 1'b0;
      h_frame_end   <= 1'b0;
      h_frame_error <= 1'b0;
      h_length      <= '0;
    end else begin
      state         <= state_nx;
      count         <= count_nx;
      err           <= err_nx;
      h_data        <= take ? emit_byte : h_data;
      h_data_strobe <= take;
      h_frame_end   <= close;
      h_frame_error <= close ? close_err : h_frame_error;
      h_length      <= close ? count : h_length;
    end
endmodule

// File: tb/tb_serial_unescape.sv
// tb_serial_unescape: directed stimulus against a byte-level reference model of serial_unescape
module tb_serial_unescape;
`ifdef SERIAL_UNESCAPE_FCS_EN
  localparam int ML = 12;
`else
  localparam int ML = 4;
`endif
  logic mclk = 1'b0, reset = 1'b0, u_data_strobe = 1'b0;
  logic [7:0] u_data = '0, h_data;
  logic h_data_strobe, h_frame_end, h_frame_error;
  logic [10:0] h_length;
  int total = 0, passed = 0;
  bit m_hunt = 1, m_esc = 0, m_err = 0;
  int m_cnt = 0;
  logic [15:0] m_crc = 16'hffff;
  logic [7:0] exp_data = 0;
  bit exp_ds = 0, exp_fe = 0, exp_err = 0;
  int exp_len = 0;
  serial_unescape #(.MAX_LEN(ML), .LEN_W(11)) dut (
    .mclk(mclk), .reset(reset), .u_data(u_data), .u_data_strobe(u_data_strobe),
    .h_data(h_data), .h_data_strobe(h_data_strobe), .h_frame_end(h_frame_end),
    .h_frame_error(h_frame_error), .h_length(h_length)
  );
  always #10 mclk = ~mclk;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r = c;
    for (int i = 0; i < 8; i++) begin
      logic fb = r[0] ^ d[i];
      r = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask
  task automatic model(input logic [7:0] b);
    bit close = 0, ab = 0, pay = 0;
    logic [7:0] pb = b;
    exp_ds = 0;
    exp_fe = 0;
    if (m_hunt) begin
      if (b == 8'h7e) begin
        m_hunt = 0; m_cnt = 0; m_err = 0; m_crc = 16'hffff;
      end
    end else if (m_esc) begin
      m_esc = 0;
      if (b == 8'h7e) begin close = 1; ab = 1; end
      else if (b == 8'h7d) m_err = 1;
      else begin pay = 1; pb = b ^ 8'h20; end
    end else if (b == 8'h7e) close = (m_cnt > 0) || m_err;
    else if (b == 8'h7d) m_esc = 1;
    else pay = 1;
    if (pay) begin
      if (m_cnt < ML) begin
        exp_data = pb; exp_ds = 1; m_cnt++; m_crc = crc_step(m_crc, pb);
      end else m_err = 1;
    end
    if (close) begin
      exp_fe = 1;
      exp_len = m_cnt;
      exp_err = m_err | ab;
`ifdef SERIAL_UNESCAPE_FCS_EN
      exp_err = exp_err | (m_crc != 16'hf0b8) | (m_cnt < 3);
`endif
      m_cnt = 0; m_err = 0; m_crc = 16'hffff;
    end
  endtask
  task automatic compare();
    chk("h_data_strobe", int'(h_data_strobe), int'(exp_ds));
    chk("h_frame_end", int'(h_frame_end), int'(exp_fe));
    chk("h_data", int'(h_data), int'(exp_data));
    chk("h_length", int'(h_length), exp_len);
    if (exp_fe) chk("h_frame_error", int'(h_frame_error), int'(exp_err));
  endtask
  task automatic send(input logic [7:0] b);
    u_data = b;
    u_data_strobe = 1;
    model(b);
    @(posedge mclk);
    #1 u_data_strobe = 0;
    compare();
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      exp_ds = 0;
      exp_fe = 0;
      @(posedge mclk);
      #1 compare();
    end
  endtask
  initial begin
    repeat (2) @(posedge mclk);
    #1 compare();
    chk("reset_data_strobe", int'(h_data_strobe), 0);
    reset = 1;
    idle(2);
    send(8'h7e); send(8'h01);
    chk("t1_byte1", int'(h_data), 8'h01);
    send(8'h02); idle(1); send(8'h03); send(8'h7e);
    chk("t1_len", int'(h_length), 3);
`ifndef SERIAL_UNESCAPE_FCS_EN
    chk("t1_err", int'(h_frame_error), 0);
`endif
    idle(2);
    send(8'h7e); send(8'h7d); send(8'h5e);
    chk("t2_byte1", int'(h_data), 8'h7e);
    send(8'h7d); send(8'h5d);
    chk("t2_byte2", int'(h_data), 8'h7d);
    send(8'h41); send(8'h7e);
    chk("t2_len", int'(h_length), 3);
    send(8'h55); send(8'h7e); send(8'h7e); send(8'h7e);
    chk("t3_no_pulse", int'(h_frame_end), 0);
    send(8'h10); send(8'h7e);
    chk("t3_len", int'(h_length), 1);
    send(8'h7e); send(8'h01); send(8'h7d); send(8'h7e);
    chk("t4_abort_err", int'(h_frame_error), 1);
    chk("t4_abort_len", int'(h_length), 1);
    send(8'h02); send(8'h7e);
    chk("t4_len", int'(h_length), 1);
    send(8'h7e); send(8'h7d); send(8'h7d); send(8'h7e);
    chk("t4_badesc_end", int'(h_frame_end), 1);
    chk("t4_badesc_len", int'(h_length), 0);
    chk("t4_badesc_err", int'(h_frame_error), 1);
    send(8'h7e);
    for (int i = 0; i < ML + 2; i++) send(8'h00);
    send(8'h7e);
    chk("t5_len", int'(h_length), ML);
    chk("t5_err", int'(h_frame_error), 1);
`ifdef SERIAL_UNESCAPE_FCS_EN
    for (int k = 0; k < 2; k++) begin
      send(8'h7e);
      for (int i = 0; i < 9; i++) send(8'h31 + 8'(i));
      send(8'h6e); send(k == 0 ? 8'h90 : 8'h91); send(8'h7e);
      chk("t6_len", int'(h_length), 11);
      chk("t6_err", int'(h_frame_error), k);
    end
`endif
    send(8'h7e); send(8'h01); send(8'h02);
    #3 reset = 0;
    #1;
    chk("rst_data", int'(h_data), 0);
    chk("rst_strobe", int'(h_data_strobe), 0);
    chk("rst_end", int'(h_frame_end), 0);
    chk("rst_err", int'(h_frame_error), 0);
    chk("rst_len", int'(h_length), 0);
    m_hunt = 1; m_esc = 0; m_cnt = 0; m_err = 0; m_crc = 16'hffff;
    exp_data = 0; exp_ds = 0; exp_fe = 0; exp_err = 0; exp_len = 0;
    @(posedge mclk);
    #1 reset = 1;
    send(8'h05); send(8'h7e);
    chk("t7_hunt_strobe", int'(h_data_strobe), 0);
    chk("t7_hunt_end", int'(h_frame_end), 0);
    idle(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
